// File: rtl/psum_accumulator_pkg.sv
// Shared types and saturating-add helper for the partial-sum accumulator.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  // Wide enough to hold any sign-extended ACC_WIDTH sum without wrap (ACC_WIDTH <= 62).
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] value;
  } sat_result_t;

  // Adds two sign-extended operands and clamps to the signed range of 'width' bits.
  function automatic sat_result_t sat_add(input logic signed [SAT_W-1:0] a,
                                          input logic signed [SAT_W-1:0] b,
                                          input int unsigned              width);
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_result_t             res;
    sum       = a + b;
    max_v     = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    min_v     = ~max_v;
    res.sat   = 1'b0;
    res.value = sum;
    if (sum > max_v) begin
      res.sat   = 1'b1;
      res.value = max_v;
    end else if (sum < min_v) begin
      res.sat   = 1'b1;
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_lane_sat_add.sv
// One accumulator lane: sign-extend both operands and add with saturation.
module psum_lane_sat_add
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic [ACC_WIDTH-1:0]  base,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0]  sum_c,
  output logic                  sat_c
);

  sat_result_t res;
  logic        unused_hi;

  always_comb begin
    res   = sat_add(SAT_W'($signed(base)), SAT_W'($signed(addend)), ACC_WIDTH);
    sum_c = res.value[ACC_WIDTH-1:0];
    sat_c = res.sat;
  end

  // Upper bits are the clamped sign extension and carry no information.
  assign unused_hi = ^res.value[SAT_W-1:ACC_WIDTH];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates partial-sum rows for one OA tile, seeding each row with bias on first
// write, then drains the finished rows downstream over valid/ready.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  localparam int unsigned ROW_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tile_calc_start,
  input  logic                         partial_sum_calc_over,
  input  logic                         tile_calc_over,
  input  logic [SIZE*DATA_WIDTH-1:0]   bias_in,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  input  logic [ROW_W-1:0]             psum_row,
  input  logic [SIZE*DATA_WIDTH-1:0]   psum_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROW_W-1:0]             out_row,
  output logic [SIZE*ACC_WIDTH-1:0]    out_data,
  output logic [15:0]                  pass_cnt,
  output logic                         sat_flag,
  output logic                         proto_err
);

  localparam int unsigned ROW_LAST = SIZE - 1;

  acc_state_e                           state;
  logic                                 start_d, ps_over_d, tile_over_d;
  logic                                 start_p, ps_over_p, tile_over_p;
  logic [SIZE-1:0][SIZE*ACC_WIDTH-1:0]  acc;
  logic [SIZE-1:0]                      written;
  logic                                 beat_acc, row_ok, seed;
  logic [SIZE*ACC_WIDTH-1:0]            cur_row, new_row, drain_row;
  logic [SIZE-1:0]                      lane_sat;
  logic [ROW_W-1:0]                     src_row;
  logic [15:0]                          pass_next;

  assign start_p     = tile_calc_start & ~start_d;
  assign ps_over_p   = partial_sum_calc_over & ~ps_over_d;
  assign tile_over_p = tile_calc_over & ~tile_over_d;

  assign beat_acc = psum_valid & psum_ready;
  assign row_ok   = 32'(psum_row) < SIZE;
  assign seed     = ~written[psum_row];
  assign cur_row  = acc[psum_row];

  // Seed path substitutes bias for the stored row so one adder serves both cases.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [ACC_WIDTH-1:0] base;
    assign base = seed ? ACC_WIDTH'($signed(bias_in[i*DATA_WIDTH +: DATA_WIDTH]))
                       : cur_row[i*ACC_WIDTH +: ACC_WIDTH];
    psum_lane_sat_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_add (
      .base   (base),
      .addend (psum_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .sum_c  (new_row[i*ACC_WIDTH +: ACC_WIDTH]),
      .sat_c  (lane_sat[i])
    );
  end

  // Next drain row; bypasses a beat landing on the same edge that starts the drain.
  always_comb begin
    src_row = '0;
    if (state == DRAIN) src_row = ROW_W'(out_row + 1'b1);
    drain_row = written[src_row] ? acc[src_row] : '0;
    if (beat_acc && row_ok && (psum_row == src_row)) drain_row = new_row;
  end

  always_comb begin
    pass_next = pass_cnt;
    if ((state == IDLE) && start_p) pass_next = '0;
    if (ps_over_p && (pass_next != 16'hFFFF)) pass_next = pass_next + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      ps_over_d   <= 1'b0;
      tile_over_d <= 1'b0;
      psum_ready  <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_data    <= '0;
      pass_cnt    <= '0;
      sat_flag    <= 1'b0;
      proto_err   <= 1'b0;
      acc         <= '0;
      written     <= '0;
    end else begin
      start_d     <= tile_calc_start;
      ps_over_d   <= partial_sum_calc_over;
      tile_over_d <= tile_calc_over;
      pass_cnt    <= pass_next;
      case (state)
        IDLE: begin
          if (tile_over_p) proto_err <= 1'b1;
          if (start_p) begin
            state      <= ACCUM;
            psum_ready <= 1'b1;
            written    <= '0;
            sat_flag   <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            if (row_ok) begin
              acc[psum_row]     <= new_row;
              written[psum_row] <= 1'b1;
              if (|lane_sat) sat_flag <= 1'b1;
            end else begin
              proto_err <= 1'b1;
            end
          end
          if (tile_over_p) begin
            state      <= DRAIN;
            psum_ready <= 1'b0;
            out_valid  <= 1'b1;
            out_row    <= '0;
            out_data   <= drain_row;
          end
        end
        DRAIN: begin
          if (start_p) proto_err <= 1'b1;
          if (out_ready) begin
            if (32'(out_row) == ROW_LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              out_row  <= src_row;
              out_data <= drain_row;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator (SIZE=4) with an arithmetic reference model.
module tb_psum_accumulator;

  localparam int unsigned SIZE = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam longint      MAXV = 64'sd2147483647;
  localparam longint      MINV = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         tile_calc_start, partial_sum_calc_over, tile_calc_over;
  logic [127:0] bias_in, psum_data, out_data;
  logic         psum_valid, psum_ready, out_valid, out_ready;
  logic [1:0]   psum_row, out_row;
  logic [15:0]  pass_cnt;
  logic         sat_flag, proto_err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: per-row accumulators, written flags, phase and status flags.
  longint       m_acc[4][4];
  bit           m_written[4];
  int           m_state;
  int           m_pass;
  bit           m_sat, m_proto;
  logic [127:0] cap[4];

  typedef struct {
    int bias;
    int p1;
    int p2;
    int exp;
    bit exp_sat;
  } vec_t;
  vec_t vecs[5];

  psum_accumulator #(.SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tile_calc_start       (tile_calc_start),
    .partial_sum_calc_over (partial_sum_calc_over),
    .tile_calc_over        (tile_calc_over),
    .bias_in               (bias_in),
    .psum_valid            (psum_valid),
    .psum_ready            (psum_ready),
    .psum_row              (psum_row),
    .psum_data             (psum_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_row               (out_row),
    .out_data              (out_data),
    .pass_cnt              (pass_cnt),
    .sat_flag              (sat_flag),
    .proto_err             (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] splat(input int v);
    return {v, v, v, v};
  endfunction

  function automatic longint lane(input logic [127:0] v, input int i);
    return longint'($signed(v[i*32 +: 32]));
  endfunction

  function automatic logic [127:0] m_row(input int r);
    logic [127:0] x;
    x = '0;
    if (m_written[r])
      for (int i = 0; i < 4; i++) x[i*32 +: 32] = 32'(m_acc[r][i]);
    return x;
  endfunction

  function automatic int rnd_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 400)) - 200;
  endfunction

  function automatic logic [127:0] rnd_vec();
    logic [127:0] x;
    for (int i = 0; i < 4; i++) x[i*32 +: 32] = rnd_val();
    return x;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 4; r++) begin
      m_written[r] = 1'b0;
      for (int i = 0; i < 4; i++) m_acc[r][i] = 0;
    end
    m_state = 0;
    m_pass  = 0;
    m_sat   = 1'b0;
    m_proto = 1'b0;
  endtask

  task automatic m_start();
    if (m_state == 0) begin
      for (int r = 0; r < 4; r++) m_written[r] = 1'b0;
      m_pass  = 0;
      m_sat   = 1'b0;
      m_state = 1;
    end else if (m_state == 2) begin
      m_proto = 1'b1;
    end
  endtask

  task automatic m_tile();
    if (m_state == 0) m_proto = 1'b1;
    else if (m_state == 1) m_state = 2;
  endtask

  task automatic m_beat(input int row, input logic [127:0] ps, input logic [127:0] bias);
    longint v;
    if (m_state != 1) return;
    for (int i = 0; i < 4; i++) begin
      v = (m_written[row] ? m_acc[row][i] : lane(bias, i)) + lane(ps, i);
      if (v > MAXV) begin v = MAXV; m_sat = 1'b1; end
      else if (v < MINV) begin v = MINV; m_sat = 1'b1; end
      m_acc[row][i] = v;
    end
    m_written[row] = 1'b1;
  endtask

  task automatic send_beat(input int row, input logic [127:0] ps, input logic [127:0] bias);
    check("psum_ready", 128'(psum_ready), 128'(m_state == 1));
    psum_valid = 1'b1;
    psum_row   = 2'(row);
    psum_data  = ps;
    bias_in    = bias;
    @(negedge clk);
    m_beat(row, ps, bias);
  endtask

  task automatic end_beats();
    psum_valid = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit p, input bit t);
    tile_calc_start       = s;
    partial_sum_calc_over = p;
    tile_calc_over        = t;
    @(negedge clk);
    if (s) m_start();
    if (p && m_pass < 65535) m_pass++;
    if (t) m_tile();
    tile_calc_start       = 1'b0;
    partial_sum_calc_over = 1'b0;
    tile_calc_over        = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status();
    check("pass_cnt", 128'(pass_cnt), 128'(m_pass));
    check("sat_flag", 128'(sat_flag), 128'(m_sat));
    check("proto_err", 128'(proto_err), 128'(m_proto));
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_psum_ready", 128'(psum_ready), 128'(0));
    check("rst_pass_cnt", 128'(pass_cnt), 128'(0));
    check("rst_sat_flag", 128'(sat_flag), 128'(0));
    check("rst_proto_err", 128'(proto_err), 128'(0));
  endtask

  // Drains all rows; pat_len = 0 gives random out_ready, else pat bit n drives cycle n.
  task automatic do_drain(input logic [15:0] pat, input int pat_len);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 200) begin
      check("drain_valid", 128'(out_valid), 128'(1));
      check("drain_row", 128'(out_row), 128'(idx));
      check("drain_data", out_data, m_row(idx));
      check("drain_psum_ready", 128'(psum_ready), 128'(0));
      cap[idx] = out_data;
      if (pat_len == 0) rdy = 1'($urandom_range(0, 1));
      else rdy = (cyc < pat_len) ? pat[cyc] : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (idx < 4) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d rows expected 4", idx);
    end
    check("drain_done_valid", 128'(out_valid), 128'(0));
    m_state = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    tile_calc_start = 1'b0;
    partial_sum_calc_over = 1'b0;
    tile_calc_over = 1'b0;
    bias_in = '0;
    psum_data = '0;
    psum_valid = 1'b0;
    psum_row = '0;
    out_ready = 1'b0;
    m_reset();

    vecs[0] = '{10, 1, 0, 11, 1'b0};
    vecs[1] = '{32'h7FFFFFF0, 32'h100, 0, 32'h7FFFFFFF, 1'b1};
    vecs[2] = '{int'(32'h80000005), -10, 0, int'(32'h80000000), 1'b1};
    vecs[3] = '{32'h7FFFFFF0, 32'h100, -1, 32'h7FFFFFFE, 1'b1};
    vecs[4] = '{3, 7, -20, -10, 1'b0};

    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);

    // Bias seed on first write
    pulse(1, 0, 0);
    check_status();
    for (int r = 0; r < 4; r++) send_beat(r, splat(1), pack4(10, 20, 30, 40));
    end_beats();
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    do_drain(16'hFFFF, 16);
    for (int r = 0; r < 4; r++) check("seed_row", cap[r], pack4(11, 21, 31, 41));
    check("seed_pass", 128'(pass_cnt), 128'(1));

    // Two passes within one OA tile
    pulse(1, 0, 0);
    for (int r = 0; r < 4; r++) send_beat(r, splat(1), pack4(10, 20, 30, 40));
    end_beats();
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    for (int r = 0; r < 4; r++) send_beat(r, pack4(2, -3, 0, 5), splat(0));
    end_beats();
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    do_drain(16'hFFFF, 16);
    for (int r = 0; r < 4; r++) check("multi_row", cap[r], pack4(13, 18, 31, 46));
    check("multi_pass", 128'(pass_cnt), 128'(2));

    // Saturation / lane arithmetic table, back-to-back beats to row 0
    foreach (vecs[k]) begin
      pulse(1, 0, 0);
      check_status();
      send_beat(0, splat(vecs[k].p1), splat(vecs[k].bias));
      send_beat(0, splat(vecs[k].p2), splat(0));
      end_beats();
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      do_drain(16'h0, 0);
      check("vec_row0", cap[0], splat(vecs[k].exp));
      check("vec_sat", 128'(sat_flag), 128'(vecs[k].exp_sat));
      check_status();
    end

    // Backpressure with a beat offered during drain
    pulse(1, 0, 0);
    for (int r = 0; r < 4; r++) send_beat(r, splat(r + 5), splat(100 * r));
    send_beat(1, splat(-7), splat(0));
    end_beats();
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    psum_valid = 1'b1;
    psum_row = 2'd2;
    psum_data = splat(1000);
    do_drain(16'h0059, 7);
    psum_valid = 1'b0;
    check("bp_row1", cap[1], splat(99));
    check("bp_row2", cap[2], splat(207));

    // Only row 2 written
    pulse(1, 0, 0);
    send_beat(2, splat(7), splat(3));
    end_beats();
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    do_drain(16'h0, 0);
    check("partial_row0", cap[0], 128'(0));
    check("partial_row1", cap[1], 128'(0));
    check("partial_row2", cap[2], splat(10));
    check("partial_row3", cap[3], 128'(0));

    // tile_calc_over while idle is a protocol error
    pulse(0, 0, 1);
    check_status();
    check("idle_out_valid", 128'(out_valid), 128'(0));

    // Start with ps_over in one cycle; beat coinciding with tile_calc_over
    pulse(1, 1, 0);
    check("start_psover_pass", 128'(pass_cnt), 128'(1));
    send_beat(0, splat(4), splat(1));
    end_beats();
    psum_valid = 1'b1;
    psum_row = 2'd3;
    psum_data = splat(-2);
    bias_in = splat(9);
    tile_calc_over = 1'b1;
    @(negedge clk);
    m_beat(3, splat(-2), splat(9));
    m_tile();
    psum_valid = 1'b0;
    tile_calc_over = 1'b0;
    @(negedge clk);
    do_drain(16'h0, 0);
    check("simul_row0", cap[0], splat(5));
    check("simul_row3", cap[3], splat(7));

    // Randomized OA tiles against the model
    for (int t = 0; t < 8; t++) begin
      int npass;
      int nbeats;
      npass = int'($urandom_range(1, 3));
      pulse(1, 0, 0);
      for (int p = 0; p < npass; p++) begin
        if (p > 0) pulse(1, 0, 0);
        nbeats = int'($urandom_range(0, 6));
        for (int b = 0; b < nbeats; b++)
          send_beat(int'($urandom_range(0, 3)), rnd_vec(), (p == 0) ? rnd_vec() : 128'(0));
        end_beats();
        pulse(0, 1, 0);
      end
      check_status();
      pulse(0, 0, 1);
      do_drain(16'h0, 0);
      check_status();
    end

    // Reset mid-drain, then start pulse during a later drain
    pulse(1, 0, 0);
    for (int r = 0; r < 4; r++) send_beat(r, splat(r + 1), splat(50));
    end_beats();
    pulse(0, 0, 1);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_row", 128'(out_row), 128'(2));
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(1, splat(99), splat(0));
    end_beats();
    check("post_reset_out_valid", 128'(out_valid), 128'(0));
    pulse(1, 0, 0);
    send_beat(3, splat(6), splat(-1));
    end_beats();
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    check("drain_start_proto", 128'(proto_err), 128'(1));
    check("drain_start_valid", 128'(out_valid), 128'(1));
    check("drain_start_row", 128'(out_row), 128'(0));
    do_drain(16'h0, 0);
    check("after_rst_row1", cap[1], 128'(0));
    check("after_rst_row3", cap[3], splat(5));
    check_status();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
